// File: rtl/ram_bist_if.sv
// RAM port bundle between the BIST initiator (master)
// and the synchronous RAM (slave).
interface ram_bist_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic              select;
  logic [DATA_W-1:0] data_out;

  modport master (
    output address,
    output data_in,
    output write,
    output select,
    input  data_out
  );

  modport slave (
    input  address,
    input  data_in,
    input  write,
    input  select,
    output data_out
  );
endinterface

// File: rtl/ram_bist.sv
// Two-pass write/read-compare march BIST for a small
// synchronous RAM; reports pass, error count, first fail.
module ram_bist #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  ram_bist_if.master        ram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_R0,
    S_D0,
    S_W1,
    S_R1,
    S_D1,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_exp;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic              r_cmp_en;
  logic [CNT_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_ffa;
  logic              r_pass;
  logic [DATA_W-1:0] w_p0;
  logic [DATA_W-1:0] w_p1;
  logic [DATA_W-1:0] w_din;
  logic [DATA_W-1:0] w_rd_exp;
  logic              w_sel;
  logic              w_wr;
  logic              w_rd;
  logic              w_done;
  logic              w_go;
  logic              w_mis;

  assign w_p0       = r_seed ^ DATA_W'(r_addr);
  assign w_p1       = ~w_p0;
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_rd_exp   = (r_state == S_R1) ? w_p1 : w_p0;
  assign w_go       = (r_state == S_IDLE) && start;
  assign w_mis      = r_cmp_en && (ram.data_out != r_exp);

  always_comb begin
    w_next     = r_state;
    w_addr_nxt = r_addr;
    w_sel      = 1'b0;
    w_wr       = 1'b0;
    w_rd       = 1'b0;
    w_din      = '0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_W0;
          w_addr_nxt = '0;
        end
      end
      S_W0, S_W1: begin
        w_sel      = 1'b1;
        w_wr       = 1'b1;
        w_din      = (r_state == S_W1) ? w_p1 : w_p0;
        w_addr_nxt = w_addr_inc;
        if (r_addr == LAST)
          w_next = (r_state == S_W1) ? S_R1 : S_R0;
      end
      S_R0, S_R1: begin
        w_sel      = 1'b1;
        w_rd       = 1'b1;
        w_addr_nxt = w_addr_inc;
        if (r_addr == LAST)
          w_next = (r_state == S_R1) ? S_D1 : S_D0;
      end
      S_D0: begin
        w_next     = S_W1;
        w_addr_nxt = '0;
      end
      S_D1: begin
        w_next     = S_FIN;
        w_addr_nxt = '0;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nxt;
    end
  end

  // Expected data travels with each read so the compare
  // lines up with the RAM's one-cycle read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmp_en   <= 1'b0;
      r_exp      <= '0;
      r_cmp_addr <= '0;
    end else begin
      r_cmp_en <= w_rd;
      if (w_rd) begin
        r_exp      <= w_rd_exp;
        r_cmp_addr <= r_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_seed <= '0;
      r_err  <= '0;
      r_ffa  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_go) begin
        r_seed <= seed;
        r_err  <= '0;
        r_ffa  <= '0;
        r_pass <= 1'b0;
      end else if (w_mis) begin
        if (r_err != '1)
          r_err <= r_err + CNT_W'(1);
        if (r_err == '0)
          r_ffa <= r_cmp_addr;
      end
      if (w_done)
        r_pass <= (r_err == '0);
    end
  end

  assign ram.address     = r_addr;
  assign ram.data_in     = w_din;
  assign ram.write       = w_wr;
  assign ram.select      = w_sel;
  assign busy            = (r_state != S_IDLE);
  assign done            = w_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_fail_addr = r_ffa;

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator for the small synchronous RAM block. Drives the RAM port (address, data_in, write, select) and checks data_out.
- Runs a two-pass write/read-compare march over every location and reports pass/fail, an error count and the first failing address.
- Sits between top-level test control and the RAM. When idle it drives a quiescent port: select=0, write=0.

Parameters:
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W locations.
- DATA_W, 8, RAM data width.
- CNT_W, 5, error counter width; counter saturates at all-ones.

Ports:
- clock  in  1  rising-edge clock shared with the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a test; sampled only in IDLE.
- seed  in  DATA_W  pattern seed; latched on accepted start.
- address  out  ADDR_W  RAM address.
- data_in  out  DATA_W  RAM write data.
- write  out  1  RAM write enable.
- select  out  1  RAM chip select.
- data_out  in  DATA_W  RAM read data; valid one cycle after a read is issued.
- busy  out  1  high from the cycle after start is accepted through the FIN cycle.
- done  out  1  one-cycle pulse in FIN.
- pass  out  1  result of the last completed test.
- err_count  out  CNT_W  number of mismatches, saturating.
- first_fail_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Clock and reset: one clock domain (clock); reset_n is asynchronous, active-low.
- Reset values: state=IDLE, address=0, data_in=0, write=0, select=0, busy=0, done=0, pass=0, err_count=0, first_fail_addr=0, latched seed=0.
- RAM protocol:
  - Write: select=1, write=1 at a rising edge.
  - Read: select=1, write=0 at edge t; data_out is compared at edge t+1.
- Patterns, with S the latched seed and a the zero-extended address:
  - Pass 0 writes P0(a) = S ^ a.
  - Pass 1 writes P1(a) = ~(S ^ a).
- States:
  - IDLE: start=1 → latch seed, clear err_count/first_fail_addr/pass, go to W0 with address=0.
  - W0: write P0(address) each cycle, address+1; after address DEPTH-1 → R0, address=0.
  - R0: issue read each cycle; after DEPTH-1 → D0.
  - D0: one drain cycle, select=0, then → W1, address=0.
  - W1, R1, D1: same sequence as W0, R0, D0 using P1; D1 → FIN.
  - FIN: done=1, pass = (err_count==0), select=0 → IDLE.
- Latency: the cycle with start=1 in IDLE is cycle 0. W0 occupies cycles 1..DEPTH. With DEPTH=8, done is high in cycle 35 and busy covers cycles 1..35.
- Compare pipeline:
  - Expected value and address are registered alongside each read issue. Compare is enabled the cycle after each R0/R1 issue, including the D0/D1 cycle.
  - On mismatch: err_count increments, saturating at 2**CNT_W-1. If this is the first error of the run, capture first_fail_addr.
- Address wrap: the address counter wraps DEPTH-1 → 0 at each phase boundary. It never exceeds DEPTH-1.
- start while not IDLE is ignored; start held high re-triggers from IDLE in the cycle after FIN.
- pass, err_count and first_fail_addr hold until the next accepted start.
- Reset mid-test returns all outputs to reset values immediately. No partial write is issued after reset deasserts.
- write=1 only in W0/W1; select=0 in IDLE, D0, D1 and FIN.

Test Plan:
- Fault-free 8x8 RAM model, seed=8'h00, pulse start → writes 0..7, then reads 0..7, then writes 8'hFF..8'hF8. done in cycle 35; pass=1, err_count=0.
- seed=8'hA5 → pass-0 data at address 3 = 8'hA6, pass-1 data at address 3 = 8'h59; pass=1.
- RAM model with bit 0 stuck-at-0 at address 5, seed=0 → pass 0 expects 8'h05 (mismatch), pass 1 expects 8'hFA (passes). Result: err_count=1, first_fail_addr=5, pass=0.
- RAM with all bits stuck-at-0 everywhere, seed=0 → err_count=15 (address 0 matches in pass 0), first_fail_addr=1, pass=0. With CNT_W=3 the count saturates at 7.
- Pulse start again in cycle 10 while busy → ignored; done still in cycle 35 only.
- Assert reset_n low in cycle 20 (W1) → select, write, busy and done go to 0 immediately. Next start runs a full test to pass=1.
